// File: rtl/conv_window_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_window_feeder: walks conv windows, streams (pixel, weight) pairs.   |
// | Optional watchdog on the MAC handshake: `define CONV_FEEDER_WDOG_EN.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv_window_feeder #(
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int padding       = 0,
  parameter int stride        = 1,
  parameter int bitwidth      = 3,
  parameter int result_width  = (img_width - weight_width + 2*padding)/stride + 1,
  parameter int result_height = (img_height - weight_height + 2*padding)/stride + 1,
  parameter int img_addr_w    = 4,
  parameter int wgt_addr_w    = 2
`ifdef CONV_FEEDER_WDOG_EN
  ,
  parameter int wdog_cycles   = 16
`endif
) (
  input  logic                  clk_en,
  input  logic                  rst_n,
  input  logic                  img_wr_en,
  input  logic [img_addr_w-1:0] img_wr_addr,
  input  logic [bitwidth-1:0]   img_wr_data,
  input  logic                  wgt_wr_en,
  input  logic [wgt_addr_w-1:0] wgt_wr_addr,
  input  logic [bitwidth-1:0]   wgt_wr_data,
  input  logic                  start,
  input  logic                  mac_done,
  output logic                  conv_en,
  output logic [bitwidth-1:0]   img_cal,
  output logic [bitwidth-1:0]   weight_cal,
  output logic                  pair_valid,
  output logic [7:0]            win_row,
  output logic [7:0]            win_col,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int K     = weight_width * weight_height;
  localparam int IMG_N = img_width * img_height;
  localparam int IMW   = (IMG_N > 1) ? $clog2(IMG_N) : 1;
  localparam int KW    = $clog2(K + 1);
  localparam int KRW   = $clog2(weight_height + 1);
  localparam int KCW   = $clog2(weight_width + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [bitwidth-1:0] img_q [IMG_N];
  logic [bitwidth-1:0] wgt_q [K];

  logic [2:0]          state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KRW-1:0]      kr_q, kr_d;
  logic [KCW-1:0]      kc_q, kc_d;
  logic [7:0]          row_q, row_d;
  logic [7:0]          col_q, col_d;
  logic [bitwidth-1:0] img_cal_q, img_cal_d;
  logic [bitwidth-1:0] wgt_cal_q, wgt_cal_d;
  logic                load_w;
  logic                last_w;
  logic                in_img_w;
  logic                timeout_w;
  int                  r_w, c_w, pa_w;

`ifdef CONV_FEEDER_WDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        err_q;

  assign timeout_w = (state_q == S_WAIT) && !mac_done && (wdog_q == 32'(wdog_cycles - 1));
  assign wdog_d    = ((state_q == S_WAIT) && !mac_done && !timeout_w) ? wdog_q + 32'd1 : 32'd0;
  assign err       = err_q;

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (timeout_w) err_q <= 1'b1;
    end
  end
`else
  assign timeout_w = 1'b0;
  assign err       = 1'b0;
`endif

  assign last_w = (row_q == 8'(result_height - 1)) && (col_q == 8'(result_width - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    row_d     = row_q;
    col_d     = col_q;
    load_w    = 1'b0;
    img_cal_d = '0;
    wgt_cal_d = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_FEED;
        k_d     = '0;
        kr_d    = '0;
        kc_d    = '0;
        load_w  = 1'b1;
      end
      S_FEED: begin
        if (k_q == KW'(K - 1)) begin
          state_d = S_WAIT;
        end else begin
          k_d    = k_q + 1'b1;
          load_w = 1'b1;
          if (kc_q == KCW'(weight_width - 1)) begin
            kc_d = '0;
            kr_d = kr_q + 1'b1;
          end else begin
            kc_d = kc_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mac_done || timeout_w) begin
          if (last_w) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            if (col_q == 8'(result_width - 1)) begin
              col_d = '0;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Fetch the pair for the kernel index presented next cycle; padded taps read as zero.
    r_w      = int'(row_q) * stride + int'(kr_d) - padding;
    c_w      = int'(col_q) * stride + int'(kc_d) - padding;
    pa_w     = r_w * img_width + c_w;
    in_img_w = (r_w >= 0) && (r_w < img_height) && (c_w >= 0) && (c_w < img_width);
    if (load_w) begin
      wgt_cal_d = wgt_q[k_d];
      if (in_img_w) img_cal_d = img_q[IMW'(pa_w)];
    end
  end

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      img_cal_q <= '0;
      wgt_cal_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      row_q     <= row_d;
      col_q     <= col_d;
      img_cal_q <= img_cal_d;
      wgt_cal_q <= wgt_cal_d;
    end
  end

  // Tile storage survives reset and is frozen outside IDLE.
  always_ff @(posedge clk_en) begin
    if (rst_n && (state_q == S_IDLE)) begin
      if (img_wr_en && (32'(img_wr_addr) < 32'(IMG_N))) img_q[img_wr_addr] <= img_wr_data;
      if (wgt_wr_en && (32'(wgt_wr_addr) < 32'(K)))     wgt_q[wgt_wr_addr] <= wgt_wr_data;
    end
  end

  assign conv_en    = (state_q == S_ISSUE);
  assign pair_valid = (state_q == S_FEED);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_FEED) || (state_q == S_WAIT);
  assign done       = (state_q == S_FIN);
  assign img_cal    = img_cal_q;
  assign weight_cal = wgt_cal_q;
  assign win_row    = row_q;
  assign win_col    = col_q;

endmodule
`default_nettype wire
